// File: rtl/vga_bar_ctrl.sv
// Debounced pushbutton control of the VGA bar start positions, committed only at frame start.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 to step_evt, +1 to pending position, outputs at next frame_start.
// Backpressure: none; every accepted press or repeat produces one step, and positions saturate.
module vga_bar_ctrl #(
    parameter int H_MIN           = 216,
    parameter int H_MAX           = 816,
    parameter int V_MIN           = 27,
    parameter int V_MAX           = 427,
    parameter int STEP            = 10,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic        clk40m,
    input  logic        rst,
    input  logic        b_left,
    input  logic        b_right,
    input  logic        g_up,
    input  logic        g_down,
    input  logic        frame_start,
    output logic [10:0] blue_pos,
    output logic [9:0]  green_pos,
    output logic [3:0]  step_evt
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Channel order matches step_evt: {g_down, g_up, b_right, b_left}
    logic [3:0] raw;
    logic [3:0] sync_meta;
    logic [3:0] sync_q;

    assign raw = {g_down, g_up, b_right, b_left};

    always_ff @(posedge clk40m or posedge rst) begin
        if (rst) begin
            sync_meta <= 4'hF;
            sync_q    <= 4'hF;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic             stable;
        logic [DB_W-1:0]  db_cnt;
        rpt_state_t       state_q;
        rpt_state_t       state_d;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        logic             step_d;
        logic             step_q;

        always_ff @(posedge clk40m or posedge rst) begin
            if (rst) begin
                stable <= 1'b1;
                db_cnt <= '0;
            end else if (sync_q[i] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync_q[i];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        // A released (stable high) button overrides every state, so short
        // release glitches filtered by the debouncer never restart the repeat.
        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            step_d    = 1'b0;
            if (stable) begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        step_d    = 1'b1;
                        state_d   = DELAY;
                        rpt_cnt_d = '0;
                    end
                    DELAY: begin
                        if (rpt_cnt_q == DELAY_LAST) begin
                            step_d    = 1'b1;
                            state_d   = REPEAT;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rpt_cnt_q == PERIOD_LAST) begin
                            step_d    = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk40m or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                rpt_cnt_q <= '0;
                step_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
                step_q    <= step_d;
            end
        end

        assign step_evt[i] = step_q;
    end

    logic [10:0] nxt_blue;
    logic [10:0] nxt_blue_d;
    logic [9:0]  nxt_green;
    logic [9:0]  nxt_green_d;
    logic [11:0] blue_inc;
    logic [10:0] green_inc;

    // One extra bit so the saturation compare cannot be fooled by wrap-around
    assign blue_inc  = {1'b0, nxt_blue} + 12'(STEP);
    assign green_inc = {1'b0, nxt_green} + 11'(STEP);

    always_comb begin
        nxt_blue_d = nxt_blue;
        if (step_evt[1] && !step_evt[0]) begin
            nxt_blue_d = (blue_inc > 12'(H_MAX)) ? 11'(H_MAX) : blue_inc[10:0];
        end else if (step_evt[0] && !step_evt[1]) begin
            nxt_blue_d = ({1'b0, nxt_blue} < 12'(H_MIN + STEP)) ? 11'(H_MIN)
                                                               : nxt_blue - 11'(STEP);
        end
    end

    always_comb begin
        nxt_green_d = nxt_green;
        if (step_evt[3] && !step_evt[2]) begin
            nxt_green_d = (green_inc > 11'(V_MAX)) ? 10'(V_MAX) : green_inc[9:0];
        end else if (step_evt[2] && !step_evt[3]) begin
            nxt_green_d = ({1'b0, nxt_green} < 11'(V_MIN + STEP)) ? 10'(V_MIN)
                                                                 : nxt_green - 10'(STEP);
        end
    end

    always_ff @(posedge clk40m or posedge rst) begin
        if (rst) begin
            nxt_blue  <= 11'(H_MIN);
            nxt_green <= 10'(V_MIN);
            blue_pos  <= 11'(H_MIN);
            green_pos <= 10'(V_MIN);
        end else begin
            nxt_blue  <= nxt_blue_d;
            nxt_green <= nxt_green_d;
            if (frame_start) begin
                blue_pos  <= nxt_blue;
                green_pos <= nxt_green;
            end
        end
    end

endmodule

// File: tb/tb_vga_bar_ctrl.sv
// Directed bench for vga_bar_ctrl with short debounce/repeat timing.
`timescale 1ns/1ps
module tb_vga_bar_ctrl;

    logic        clk40m = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic        frame_start;
    logic [10:0] blue_pos;
    logic [9:0]  green_pos;
    logic [3:0]  step_evt;

    int tests = 0;
    int fails = 0;

    always #5 clk40m = ~clk40m;

    vga_bar_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk40m     (clk40m),
        .rst        (rst),
        .b_left     (btn[0]),
        .b_right    (btn[1]),
        .g_up       (btn[2]),
        .g_down     (btn[3]),
        .frame_start(frame_start),
        .blue_pos   (blue_pos),
        .green_pos  (green_pos),
        .step_evt   (step_evt)
    );

    typedef struct {
        logic [3:0]  btn;
        logic        fs;
        logic [3:0]  exp_step;
        logic [10:0] exp_blue;
        logic [9:0]  exp_green;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with outputs of the commit cycle visible.
    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk40m);
        frame_start = 1'b0;
    endtask

    // Short press (accepted, released well before any auto-repeat) plus settle time.
    task automatic press(input logic [3:0] mask, output int steps, output logic [3:0] pat);
        steps = 0;
        pat   = 4'b0;
        btn   = ~mask;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) btn = 4'hF;
            @(negedge clk40m);
            if ((step_evt & mask) != 4'b0) begin
                steps++;
                pat = step_evt;
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish within 200us");
        $fatal(1);
    end

    initial begin
        int         n;
        int         t0;
        int         offs[6];
        int         exp_offs[6];
        int         total;
        int         steps;
        logic [3:0] pat;
        logic       found;

        exp_offs = '{0, 20, 28, 36, 44, 52};

        // Per-cycle table: single b_right press, commit, then a 2-cycle g_down glitch
        for (int i = 0; i < 28; i++) begin
            vecs[i] = '{btn: 4'hF, fs: 1'b0, exp_step: 4'b0,
                        exp_blue: (i >= 16) ? 11'd226 : 11'd216, exp_green: 10'd27};
        end
        for (int i = 1; i <= 8; i++) vecs[i].btn = 4'hD;
        vecs[7].exp_step = 4'b0010;
        vecs[16].fs  = 1'b1;
        vecs[18].btn = 4'h7;
        vecs[19].btn = 4'h7;
        vecs[26].fs  = 1'b1;

        rst = 1'b1;
        btn = 4'hF;
        frame_start = 1'b0;
        repeat (3) @(negedge clk40m);
        check("reset blue_pos", 32'(blue_pos), 216);
        check("reset green_pos", 32'(green_pos), 27);
        check("reset step_evt", 32'(step_evt), 0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            btn = vecs[i].btn;
            frame_start = vecs[i].fs;
            @(negedge clk40m);
            check($sformatf("vec%0d step_evt", i), 32'(step_evt), 32'(vecs[i].exp_step));
            check($sformatf("vec%0d blue_pos", i), 32'(blue_pos), 32'(vecs[i].exp_blue));
            check($sformatf("vec%0d green_pos", i), 32'(green_pos), 32'(vecs[i].exp_green));
        end
        frame_start = 1'b0;

        // Reset asserted mid-hold, while a repeat step pulse is on the output
        btn = 4'hD;
        n = 0;
        for (int c = 0; c < 60 && n < 2; c++) begin
            @(negedge clk40m);
            if (step_evt[1]) n++;
        end
        check("hold reached 2nd step before reset", 32'(n), 2);
        rst = 1'b1;
        #1;
        check("mid-hold reset blue_pos", 32'(blue_pos), 216);
        check("mid-hold reset green_pos", 32'(green_pos), 27);
        check("mid-hold reset step_evt", 32'(step_evt), 0);
        btn = 4'hF;
        @(negedge clk40m);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk40m);
            if (step_evt != 4'b0) n++;
        end
        check("no step after reset release", 32'(n), 0);
        pulse_frame();
        check("pending blue cleared by reset", 32'(blue_pos), 216);

        // Long hold of b_right: acceptance step then auto-repeat cadence
        btn = 4'hD;
        n = 0;
        t0 = -1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk40m);
            if (step_evt[1]) begin
                if (t0 < 0) t0 = c;
                if (n < 6) offs[n] = c - t0;
                n++;
            end
            if (t0 >= 0 && c - t0 == 52) btn = 4'hF;
        end
        check("hold step count", 32'(n), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hold step %0d offset", i), (i < n) ? offs[i] : -1, exp_offs[i]);
        end
        check("blue before frame after hold", 32'(blue_pos), 216);
        pulse_frame();
        check("blue after hold commit", 32'(blue_pos), 276);

        // Saturation at H_MAX and V_MIN
        total = 0;
        for (int p = 0; p < 70; p++) begin
            press(4'b0010, steps, pat);
            total += steps;
        end
        check("70 presses step count", 32'(total), 70);
        pulse_frame();
        check("blue saturated", 32'(blue_pos), 816);
        press(4'b0010, steps, pat);
        check("extra press step", 32'(steps), 1);
        pulse_frame();
        check("blue stays at max", 32'(blue_pos), 816);
        press(4'b0100, steps, pat);
        check("g_up step", 32'(steps), 1);
        pulse_frame();
        check("green stays at min", 32'(green_pos), 27);

        // Opposing steps on the same cycle cancel
        press(4'b0001, steps, pat);
        pulse_frame();
        check("blue after left", 32'(blue_pos), 806);
        press(4'b0011, steps, pat);
        check("left+right step cycles", 32'(steps), 1);
        check("left+right step pattern", 32'(pat), 32'h3);
        pulse_frame();
        check("blue after left+right", 32'(blue_pos), 806);

        // Pending update coinciding with frame_start commits the old value
        btn = 4'hE;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk40m);
            if (step_evt[0]) found = 1'b1;
        end
        check("left step seen", 32'(found), 1);
        pulse_frame();
        check("coincident commit old value", 32'(blue_pos), 806);
        btn = 4'hF;
        repeat (12) @(negedge clk40m);
        pulse_frame();
        check("next commit new value", 32'(blue_pos), 796);
        check("green untouched", 32'(green_pos), 27);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
